// File: rtl/decode_scan_seq_if.sv
// Control and decoder-drive signals of the scan sequencer, grouped as one bundle.
// The master side owns run/div/mask; the sequencer (slave) drives x/en/frame_done.
interface decode_scan_seq_if #(
    parameter int DIV_W = 16
);
    logic             run;
    logic [DIV_W-1:0] div;
    logic [15:0]      mask;
    logic [3:0]       x;
    logic             en;
    logic             frame_done;

    modport master (
        output run, div, mask,
        input  x, en, frame_done
    );

    modport slave (
        input  run, div, mask,
        output x, en, frame_done
    );
endinterface

// File: rtl/decode_scan_seq.sv
// Scan sequencer for a 4-to-16 line decoder: walks the masked lines in ascending order,
// holding each for div+1 cycles, with an optional en-low blanking gap between lines.
module decode_scan_seq #(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    decode_scan_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

    localparam bit       HAS_BLANK  = (BLANK_CYC > 0);
    localparam bit [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

    state_t           state_q, state_d;
    logic [3:0]       x_q, x_d;
    logic             en_q, en_d;
    logic             fd_q, fd_d;
    logic [DIV_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       blank_cnt_q, blank_cnt_d;

    logic             start, adv, mask_any, dwell_last, blank_last;
    logic [DIV_W-1:0] div_eff;
    logic [3:0]       nxt_inc, nxt_exc;

    // First set mask bit at or after the start point, wrapping 15 -> 0.
    function automatic logic [3:0] nxt(input logic [3:0] from, input logic incl,
                                       input logic [15:0] m);
        logic [3:0] first, idx, res;
        first = incl ? from : from + 4'd1;
        res   = first;
        for (int k = 15; k >= 0; k--) begin
            idx = first + 4'(k);
            if (m[idx]) res = idx;
        end
        return res;
    endfunction

    assign mask_any   = (bus.mask != 16'd0);
    assign nxt_inc    = nxt(x_q, 1'b1, bus.mask);
    assign nxt_exc    = nxt(x_q, 1'b0, bus.mask);
    assign div_eff    = (dwell_cnt_q == '0) ? bus.div : div_q;
    assign dwell_last = (dwell_cnt_q == div_eff);
    assign blank_last = (blank_cnt_q == BLANK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= 4'd0;
            en_q        <= 1'b0;
            fd_q        <= 1'b0;
            dwell_cnt_q <= '0;
            div_q       <= '0;
            blank_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            en_q        <= en_d;
            fd_q        <= fd_d;
            dwell_cnt_q <= dwell_cnt_d;
            div_q       <= div_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // run low overrides everything; an advance onto an empty mask parks in IDLE.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        adv     = 1'b0;
        if (!bus.run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (mask_any) begin
                           state_d = DWELL;
                           start   = 1'b1;
                       end
                DWELL: if (dwell_last) begin
                           if (HAS_BLANK) state_d = BLANK;
                           else           adv     = 1'b1;
                       end
                BLANK: if (blank_last) adv = 1'b1;
                default: state_d = IDLE;
            endcase
            if (adv) state_d = mask_any ? DWELL : IDLE;
        end
    end

    always_comb begin
        x_d         = x_q;
        fd_d        = 1'b0;
        en_d        = (state_d == DWELL);
        div_d       = div_q;
        dwell_cnt_d = '0;
        blank_cnt_d = 8'd0;
        if (start) x_d = nxt_inc;
        if (adv && mask_any) begin
            x_d  = nxt_exc;
            fd_d = (nxt_exc <= x_q);
        end
        if (state_q == DWELL && dwell_cnt_q == '0) div_d = bus.div;
        if (state_q == DWELL && state_d == DWELL && !dwell_last)
            dwell_cnt_d = dwell_cnt_q + 1'b1;
        if (state_q == BLANK && state_d == BLANK)
            blank_cnt_d = blank_cnt_q + 8'd1;
    end

    assign bus.x          = x_q;
    assign bus.en         = en_q;
    assign bus.frame_done = fd_q;
endmodule
